traffic_countdown_disp: RTL
===========================

// Module: traffic_countdown_disp
// PURPOSE
//  Downstream of the intersection light controller. Consumes street_a/street_b colour codes and priority lamps.
//  Maintains a per-street seconds-remaining countdown for the current colour.
//  Drives a 4-digit multiplexed 7-segment display: A tens, A ones, B tens, B ones.
// PARAMETERS
//  TICK_DIV    50_000_000  clk cycles per 1 s tick (>=2)
//  SCAN_DIV    50_000      clk cycles per digit-scan step (>=1)
//  GREEN_SEC   25          count loaded on entry to green (1..99)
//  YELLOW_SEC  3           count loaded on entry to yellow (1..99)
//  RED_SEC     28          count loaded on entry to red (1..99)
// PORTS
//  clk                input   1  system clock
//  rst_n              input   1  reset
//  street_a           input   3  street A colour, one-hot {red,yellow,green}
//  street_a_pri_lamp  input   1  street A priority lamp active
//  street_b           input   3  street B colour, one-hot {red,yellow,green}
//  street_b_pri_lamp  input   1  street B priority lamp active
//  cnt_a              output  7  street A seconds remaining, binary
//  cnt_b              output  7  street B seconds remaining, binary
//  seg                output  7  segments {g,f,e,d,c,b,a}, active-high
//  digit_en           output  4  one-hot digit select [0]=A tens .. [3]=B ones
// BEHAVIOUR
//  - One clock, clk. rst_n is synchronous, active-low.
//  - Reset values: cnt_a=cnt_b=0, seg=0, digit_en=0; tick/scan counters=0; prev colour regs=3'b000.
//  - Tick: a free-running divider pulses tick for 1 cycle every TICK_DIV cycles. First tick is TICK_DIV cycles after reset release.
//  - Per street X, each rising clk edge, in priority order:
//    1) Code invalid (not one-hot, incl. 000): cntX<=0, display of X blanked.
//    2) street_X != prev_X (colour change): cntX <= duration of the new colour.
//       Visible 1 cycle after the change. A change beats a coincident tick.
//    3) Tick and !street_X_pri_lamp and cntX>0: cntX<=cntX-1. Saturates at 0, no wrap.
//    4) Otherwise cntX holds.
//    prev_X <= street_X every cycle.
//  - Priority lamp high: the countdown freezes, but colour changes still reload.
//    The digit pair for X shows "--" (seg=7'b1000000).
//    On release, counting resumes from the held value on the next tick.
//  - Display: a 2-bit scan index advances every SCAN_DIV cycles, order 0->1->2->3->0.
//    digit_en=1<<idx is registered together with seg for the same digit (no ghosting).
//    First scan step is SCAN_DIV cycles after reset; until then digit_en=0.
//  - Digit value: tens=cnt/10, ones=cnt%10 (cnt<=99 guaranteed).
//    Tens digit blanked (seg=0) when tens==0; ones always shown, incl. "0".
//  - Reset mid-count: all state returns to reset values next edge.
//    The first valid code afterwards is treated as a change and loads.
// CONFIGURATION
//  COUNTDOWN_BLINK_EN defined: while cntX<=3 and not in priority, X's digits are blanked
//    on alternate half-seconds. The phase is driven by divider >= TICK_DIV/2.
//    cntX values are unaffected.
//  Not defined: digits are steady; no blink logic is synthesized.
// STRUCTURE
//  Shared header traffic_defs.vh:
//    - colour codes RED=3'b100, YEL=3'b010, GRN=3'b001
//    - seg patterns SEG_BLANK, SEG_DASH, digits 0-9
//  Sub-module seg7_decoder: 4-bit digit + blank + dash -> 7-bit seg (combinational).
//    Instantiated once, after the scan mux.
// TESTING  (TICK_DIV=4, SCAN_DIV=2, GREEN_SEC=5, YELLOW_SEC=2, RED_SEC=7)
//  1 Reset: hold rst_n=0 for 3 cycles with A=GRN -> cnt_a=0, seg=0, digit_en=0.
//    Release -> cnt_a=5 one cycle later.
//  2 A=GRN held -> cnt_a 5,4,3,2,1,0 on successive ticks, stays 0 on later ticks (saturation).
//  3 A GRN->YEL on the same edge as a tick -> cnt_a=2 (load wins, no decrement).
//  4 B=RED, cnt_b=7; assert street_b_pri_lamp for 3 ticks -> cnt_b stays 7, digits 2,3 show dash.
//    Release -> cnt_b=6 at next tick.
//  5 Scan with cnt_a=5, cnt_b=7 -> digit_en 0001 seg=0 (tens blank), 0010 seg=digit 5,
//    0100 seg=0, 1000 seg=digit 7, repeating. Re-run with RED_SEC=12 -> tens shows "1".
//  6 Drive A=3'b011 -> cnt_a=0 and A digits blank.
//    Return to RED -> cnt_a=7. With COUNTDOWN_BLINK_EN, check blanking toggles at cnt_a<=3.

Source files
------------

// File: rtl/traffic_countdown_disp_pkg.sv
// Shared colour codes, segment patterns and digit-scan positions for the
// traffic countdown display.
package traffic_countdown_disp_pkg;

  localparam logic [2:0] COL_RED = 3'b100;
  localparam logic [2:0] COL_YEL = 3'b010;
  localparam logic [2:0] COL_GRN = 3'b001;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    DIG_A_TENS = 2'd0,
    DIG_A_ONES = 2'd1,
    DIG_B_TENS = 2'd2,
    DIG_B_ONES = 2'd3
  } digit_sel_e;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/traffic_countdown_disp_seg7_decoder.sv
// Combinational 7-segment decoder: blank overrides dash, dash overrides the digit.
module seg7_decoder
  import traffic_countdown_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_of_digit(digit);
    if (dash) seg = SEG_DASH;
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/traffic_countdown_disp.sv
// Per-street seconds-remaining countdown with a 4-digit multiplexed 7-segment
// display. Optional feature macro: COUNTDOWN_BLINK_EN (blink digits when cnt<=3).
module traffic_countdown_disp
  import traffic_countdown_disp_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int GREEN_SEC  = 25,
  parameter int YELLOW_SEC = 3,
  parameter int RED_SEC    = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] street_a,
  input  logic       street_a_pri_lamp,
  input  logic [2:0] street_b,
  input  logic       street_b_pri_lamp,
  output logic [6:0] cnt_a,
  output logic [6:0] cnt_b,
  output logic [6:0] seg,
  output logic [3:0] digit_en
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [TW-1:0] div_q, div_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          tick, scan_step;
  digit_sel_e    idx_q, idx_d;
  logic [1:0]    idx_bits;
  logic [6:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [2:0]    prev_a_q, prev_b_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit_en_q, digit_en_d;

  logic [6:0]    sel_cnt;
  logic [2:0]    sel_code;
  logic          sel_pri, blink_on;
  logic [3:0]    tens, ones, dec_digit;
  logic          dec_blank, dec_dash;
  logic [6:0]    dec_seg;

  function automatic logic [6:0] colour_dur(input logic [2:0] code);
    case (code)
      COL_RED: return 7'(RED_SEC);
      COL_YEL: return 7'(YELLOW_SEC);
      COL_GRN: return 7'(GREEN_SEC);
      default: return 7'd0;
    endcase
  endfunction

  // Invalid code clears, a colour change reloads (even on a tick), else count down.
  function automatic logic [6:0] next_cnt(input logic [2:0] code, input logic [2:0] prev,
                                          input logic tick_i, input logic pri_i,
                                          input logic [6:0] cnt);
    if (!$onehot(code)) return 7'd0;
    if (code != prev) return colour_dur(code);
    if (tick_i && !pri_i && (cnt != 7'd0)) return cnt - 7'd1;
    return cnt;
  endfunction

  always_comb begin
    tick      = (div_q == TW'(TICK_DIV - 1));
    div_d     = tick ? '0 : div_q + TW'(1);
    scan_step = (scan_q == SW'(SCAN_DIV - 1));
    scan_d    = scan_step ? '0 : scan_q + SW'(1);
    cnt_a_d   = next_cnt(street_a, prev_a_q, tick, street_a_pri_lamp, cnt_a_q);
    cnt_b_d   = next_cnt(street_b, prev_b_q, tick, street_b_pri_lamp, cnt_b_q);
  end

  // Scan mux feeds a single decoder; blanking uses the last registered colour code.
  always_comb begin
    idx_bits  = idx_q;
    sel_cnt   = idx_bits[1] ? cnt_b_q : cnt_a_q;
    sel_code  = idx_bits[1] ? prev_b_q : prev_a_q;
    sel_pri   = idx_bits[1] ? street_b_pri_lamp : street_a_pri_lamp;
    tens      = 4'(sel_cnt / 7'd10);
    ones      = 4'(sel_cnt % 7'd10);
    dec_digit = idx_bits[0] ? ones : tens;
`ifdef COUNTDOWN_BLINK_EN
    blink_on  = (sel_cnt <= 7'd3) && (div_q >= TW'(TICK_DIV / 2));
`else
    blink_on  = 1'b0;
`endif
    dec_dash  = sel_pri;
    dec_blank = !$onehot(sel_code) ||
                (!sel_pri && (blink_on || (!idx_bits[0] && (tens == 4'd0))));
  end

  seg7_decoder u_seg7_decoder (
    .digit (dec_digit),
    .blank (dec_blank),
    .dash  (dec_dash),
    .seg   (dec_seg)
  );

  // digit_en and seg update on the same edge so a digit never shows its neighbour's pattern.
  always_comb begin
    idx_d      = idx_q;
    seg_d      = seg_q;
    digit_en_d = digit_en_q;
    if (scan_step) begin
      seg_d      = dec_seg;
      digit_en_d = 4'b0001 << idx_bits;
      idx_d      = digit_sel_e'(idx_bits + 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q      <= '0;
      scan_q     <= '0;
      idx_q      <= DIG_A_TENS;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      prev_a_q   <= 3'b000;
      prev_b_q   <= 3'b000;
      seg_q      <= SEG_BLANK;
      digit_en_q <= '0;
    end else begin
      div_q      <= div_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      prev_a_q   <= street_a;
      prev_b_q   <= street_b;
      seg_q      <= seg_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign cnt_a    = cnt_a_q;
  assign cnt_b    = cnt_b_q;
  assign seg      = seg_q;
  assign digit_en = digit_en_q;

endmodule
